cmsdk_apb4_eg_master_interface: RTL
===================================

// Module: cmsdk_apb4_eg_master_interface
// PURPOSE
//  APB4 initiator (requester) that turns single-beat register commands on a valid/ready
//  port into APB4 SETUP/ACCESS transfers. Supports wait states (pready), error responses
//  (pslverr) and an optional pready timeout. Sits between a local bus/test sequencer and
//  APB4 completers such as the team's APB4 example slave interface.
// PARAMETERS
//  ADDRWIDTH  12   width of cmd_addr / paddr
//  TIMEOUT    256  max consecutive ACCESS cycles with pready=0 before abort; 0 = never
// PORTS
//  pclk         in   1          clock; all logic on rising edge
//  preset       in   1          synchronous reset, active-high
//  cmd_valid    in   1          command request
//  cmd_ready    out  1          command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1          1 = write, 0 = read
//  cmd_addr     in   ADDRWIDTH  transfer address
//  cmd_wdata    in   32         write data
//  cmd_strb     in   4          write byte strobes
//  cmd_prot     in   3          APB4 protection attributes
//  rsp_valid    out  1          response available
//  rsp_ready    in   1          response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  32         read data (0 for writes and timeouts)
//  rsp_err      out  1          pslverr sampled, or timeout
//  rsp_timeout  out  1          transfer aborted by timeout
//  psel         out  1          APB select
//  penable      out  1          APB enable
//  pwrite       out  1          APB direction
//  paddr        out  ADDRWIDTH  APB address
//  pwdata       out  32         APB write data
//  pstrb        out  4          APB strobes
//  pprot        out  3          APB protection
//  prdata       in   32         APB read data
//  pready       in   1          APB ready
//  pslverr      in   1          APB error
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, cmd_ready=1, rsp_valid=0, psel=0,
//    penable=0, pwrite=0, paddr/pwdata/pstrb/pprot=0, rsp_rdata=0, rsp_err=0,
//    rsp_timeout=0, timeout counter=0.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On accept (cycle T): latch cmd fields onto paddr/pwrite/pwdata/
//    pprot; pstrb=cmd_strb for writes, forced 4'b0000 for reads; psel=1, penable=0;
//    cmd_ready=0; enter SETUP at T+1.
//  - SETUP: lasts exactly one cycle; penable=1 from T+2 (ACCESS).
//  - ACCESS: paddr/pwrite/pwdata/pstrb/pprot held stable. Each cycle with pready=1:
//    rsp_rdata=prdata if read, else 0; rsp_err=pslverr; rsp_timeout=0; psel=penable=0;
//    rsp_valid=1; enter RESP. Zero-wait read: accept at T, rsp_valid at T+3.
//  - Timeout (TIMEOUT>0): counter clears on SETUP entry and increments each ACCESS cycle
//    with pready=0. When pready=0 and counter==TIMEOUT-1, abort: psel=penable=0,
//    rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. pready=1 in the same cycle as
//    the limit wins (normal completion). Counter width = clog2(TIMEOUT+1).
//  - RESP: rsp_* held stable while rsp_valid=1 & rsp_ready=0. On rsp_ready=1: rsp_valid=0,
//    cmd_ready=1, IDLE next cycle. No new command accepted in RESP (one outstanding max).
//  - pslverr ignored outside ACCESS; pready ignored outside ACCESS.
//  - paddr/pwdata/pstrb/pprot keep last value when idle (no forced zero).
//  - Reset mid-transfer: immediate return to reset values on next edge; transfer dropped,
//    no response generated.
// TESTING
//  1 Write 0x008 data 0xDEADBEEF strb 0xF, pready=1 -> psel T+1, penable T+2, rsp_valid
//    T+3, rsp_err=0, rsp_rdata=0.
//  2 Read 0x010, pready low 3 ACCESS cycles then prdata=0x12345678 -> penable 4 cycles,
//    pstrb=0, rsp_rdata=0x12345678, addr stable throughout.
//  3 Write with pslverr=1 at completion -> rsp_err=1, rsp_timeout=0.
//  4 TIMEOUT=4, pready stuck 0 -> abort after 4th ACCESS cycle, rsp_err=1, rsp_timeout=1.
//  5 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> cmd_ready=0, rsp_* stable, second
//    cmd accepted only after IDLE.
//  6 preset asserted during ACCESS -> next edge psel=penable=0, rsp_valid=0, cmd_ready=1.

Source files
------------

// File: rtl/cmsdk_apb4_eg_master_interface.sv
// APB4 requester: turns single-beat valid/ready register commands into
// APB4 SETUP/ACCESS transfers, with wait states, slave errors and an optional pready timeout.
module cmsdk_apb4_eg_master_interface #(
    parameter int ADDRWIDTH = 12,
    parameter int TIMEOUT   = 256
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_strb,
    input  logic [2:0]           cmd_prot,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic [31:0]          pwdata,
    output logic [3:0]           pstrb,
    output logic [2:0]           pprot,
    input  logic [31:0]          prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    // A zero TIMEOUT disables the abort; keep the counter at least one bit wide.
    localparam bit HAS_TO = (TIMEOUT > 0);
    localparam int CW     = HAS_TO ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = HAS_TO ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] tcnt;

    // Transfer sequencer; every output is a register updated here.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            tcnt        <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_wdata;
                        pprot     <= cmd_prot;
                        // Reads never carry strobes on APB4.
                        pstrb     <= cmd_write ? cmd_strb : 4'b0000;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        cmd_ready <= 1'b0;
                        tcnt      <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A ready completer wins over a simultaneous timeout.
                    if (pready) begin
                        rsp_rdata   <= pwrite ? 32'h0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else if (HAS_TO && (tcnt == LIMIT)) begin
                        rsp_rdata   <= 32'h0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
